// File: rtl/audio_i2s_tx_pkg.sv
// rtl/audio_i2s_tx_pkg.sv - shared constants and helpers for the I2S audio transmitter
//
// Purpose: sample width, frame counter width, clock tap positions on the frame
// counter, word-select polarity, and the slot-to-bit-index helper.
package audio_i2s_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 9;

  // Bit positions of the frame counter that directly drive the output clocks.
  localparam int MCLK_TAP = 1;   // clk/4
  localparam int SCK_TAP  = 3;   // clk/16
  localparam int LRCK_TAP = 8;   // clk/512

  // Word-select polarity.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // With the one-SCK I2S delay, slot s (1..31) carries bit (16 - s) mod 16 of
  // its word: slots 1..16 walk frame_l[15..0], slots 17..31 walk frame_r[15..1].
  function automatic logic [3:0] slot_bit_idx(input logic [4:0] slot);
    return 4'd0 - slot[3:0];
  endfunction

endpackage

// File: rtl/audio_i2s_tx_clk_gen.sv
// rtl/audio_i2s_tx_clk_gen.sv - free-running frame counter and I2S clock taps
//
// Purpose: 9-bit counter (+1 per clk, wraps 511 -> 0) whose bits drive the
// DAC clocks directly, so all clocks come straight from flops.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   cnt_o        current counter value
//   mclk_o       master clock, clk/4
//   sck_o        bit clock, clk/16
//   lrck_o       word select, clk/512 (low = left)
//   frame_end_o  high in the last cycle of a frame (cnt = 511)
module audio_clk_gen
  import audio_i2s_tx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] cnt_o,
  output logic             mclk_o,
  output logic             sck_o,
  output logic             lrck_o,
  output logic             frame_end_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign mclk_o      = cnt_q[MCLK_TAP];
  assign sck_o       = cnt_q[SCK_TAP];
  assign lrck_o      = cnt_q[LRCK_TAP] ? LRCK_RIGHT : LRCK_LEFT;
  assign frame_end_o = &cnt_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - stereo I2S transmitter with per-frame sample latch and mute
//
// Purpose: latches one stereo sample per 512-clk frame and shifts it out in
// I2S format (MSB first, data one SCK behind word select).
// Ports:
//   clk          100 MHz system clock
//   rst_n        asynchronous active-low reset
//   audio_left   left sample, captured only when sample_req is high
//   audio_right  right sample, captured only when sample_req is high
//   mute         zeroes the captured frame when high in the sample_req cycle
//   sample_req   one-cycle pulse, the cycle in which inputs are captured
//   audio_mclk   DAC master clock, clk/4
//   audio_sck    serial bit clock, clk/16
//   audio_lrck   word select, low = left, high = right
//   audio_sdin   serial data, changes on SCK falling edges
module audio_i2s_tx #(
  parameter int SAMPLE_W = audio_i2s_tx_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  input  logic                mute,
  output logic                sample_req,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin
);

  import audio_i2s_tx_pkg::*;

  logic [CNT_W-1:0]    cnt;
  logic                frame_end;

  logic [SAMPLE_W-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_W-1:0] frame_r_q, frame_r_d;
  logic                prev_r0_q, prev_r0_d;
  logic                sdin_q, sdin_d;

  logic [4:0]          next_slot;
  logic [3:0]          bit_idx;
  logic                slot_last_clk;

  audio_clk_gen u_clk_gen (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cnt_o       (cnt),
    .mclk_o      (audio_mclk),
    .sck_o       (audio_sck),
    .lrck_o      (audio_lrck),
    .frame_end_o (frame_end)
  );

  // sdin only moves on the edge that starts a new slot (SCK falling), so the
  // bit is chosen for the slot about to begin.
  assign slot_last_clk = (cnt[3:0] == 4'hF);
  assign next_slot     = cnt[CNT_W-1:4] + 5'd1;
  assign bit_idx       = slot_bit_idx(next_slot);

  always_comb begin
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    prev_r0_d = prev_r0_q;
    sdin_d    = sdin_q;

    if (frame_end) begin
      frame_l_d = mute ? '0 : audio_left;
      frame_r_d = mute ? '0 : audio_right;
      prev_r0_d = frame_r_q[0];
    end

    // Selecting from the _d values lets slot 0 pick up the right LSB that is
    // being retired on the very same wrap edge.
    if (slot_last_clk) begin
      if (next_slot == 5'd0) begin
        sdin_d = prev_r0_d;
      end else if (next_slot <= 5'd16) begin
        sdin_d = frame_l_d[bit_idx];
      end else begin
        sdin_d = frame_r_d[bit_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_l_q <= '0;
      frame_r_q <= '0;
      prev_r0_q <= 1'b0;
      sdin_q    <= 1'b0;
    end else begin
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      prev_r0_q <= prev_r0_d;
      sdin_q    <= sdin_d;
    end
  end

  assign sample_req = frame_end;
  assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - directed self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = 16'h0;
  logic [15:0] audio_right = 16'h0;
  logic        mute = 1'b0;
  logic        sample_req;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference frame position: restarts with reset, +1 per clk.
  logic [8:0] m_cnt;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 9'd0;
    else        m_cnt <= m_cnt + 9'd1;
  end

  audio_i2s_tx #(.SAMPLE_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .mute        (mute),
    .sample_req  (sample_req),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .audio_sdin  (audio_sdin)
  );

  // Advance at least one negedge, stop at the negedge where the frame
  // position equals v.
  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_cnt != 9'(v) && k < 1100);
    if (m_cnt != 9'(v)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cnt: position %0d, required %0d", m_cnt, v);
    end
  endtask

  // Samples mid-slot; result bit 31 = slot 0, bit 0 = slot 31.
  task automatic read_frame(output logic [31:0] bits);
    bits = '0;
    for (int s = 0; s < 32; s++) begin
      wait_cnt(s * 16 + 8);
      bits = {bits[30:0], audio_sdin};
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sample_req !== 1'b0) begin n_bad++; $display("FAIL reset_sample_req: got %b want 0", sample_req); end
    n_cmp++; if (audio_mclk !== 1'b0) begin n_bad++; $display("FAIL reset_mclk: got %b want 0", audio_mclk); end
    n_cmp++; if (audio_sck  !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", audio_sck); end
    n_cmp++; if (audio_lrck !== 1'b0) begin n_bad++; $display("FAIL reset_lrck: got %b want 0", audio_lrck); end
    n_cmp++; if (audio_sdin !== 1'b0) begin n_bad++; $display("FAIL reset_sdin: got %b want 0", audio_sdin); end
    rst_n = 1'b1;
  endtask

  task automatic test_clocks;
    int e_mclk, e_sck, e_lrck, e_req, e_sdin;
    int r_mclk, r_sck, r_lrck, r_req;
    logic p_mclk, p_sck, p_lrck, p_req;
    e_mclk = 0; e_sck = 0; e_lrck = 0; e_req = 0; e_sdin = 0;
    r_mclk = 0; r_sck = 0; r_lrck = 0; r_req = 0;
    p_mclk = 1'b0; p_sck = 1'b0; p_lrck = 1'b0; p_req = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (audio_mclk !== m_cnt[1]) e_mclk++;
      if (audio_sck  !== m_cnt[3]) e_sck++;
      if (audio_lrck !== m_cnt[8]) e_lrck++;
      if (sample_req !== (m_cnt == 9'd511)) e_req++;
      if (audio_sdin !== 1'b0) e_sdin++;
      if (audio_mclk === 1'b1 && !p_mclk) r_mclk++;
      if (audio_sck  === 1'b1 && !p_sck)  r_sck++;
      if (audio_lrck === 1'b1 && !p_lrck) r_lrck++;
      if (sample_req === 1'b1 && !p_req)  r_req++;
      p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck; p_req = sample_req;
    end
    n_cmp++; if (e_mclk != 0) begin n_bad++; $display("FAIL mclk_phase: %0d bad cycles, want 0", e_mclk); end
    n_cmp++; if (e_sck  != 0) begin n_bad++; $display("FAIL sck_phase: %0d bad cycles, want 0", e_sck); end
    n_cmp++; if (e_lrck != 0) begin n_bad++; $display("FAIL lrck_phase: %0d bad cycles, want 0", e_lrck); end
    n_cmp++; if (e_req  != 0) begin n_bad++; $display("FAIL sample_req_phase: %0d bad cycles, want 0", e_req); end
    n_cmp++; if (e_sdin != 0) begin n_bad++; $display("FAIL zero_frame_sdin: %0d nonzero cycles, want 0", e_sdin); end
    n_cmp++; if (r_mclk != 256) begin n_bad++; $display("FAIL mclk_period: %0d rises, want 256", r_mclk); end
    n_cmp++; if (r_sck  != 64)  begin n_bad++; $display("FAIL sck_period: %0d rises, want 64", r_sck); end
    n_cmp++; if (r_lrck != 2)   begin n_bad++; $display("FAIL lrck_period: %0d rises, want 2", r_lrck); end
    n_cmp++; if (r_req  != 2)   begin n_bad++; $display("FAIL sample_req_rate: %0d pulses, want 2", r_req); end
  endtask

  task automatic test_frame;
    logic [31:0] bits;
    wait_cnt(400);
    audio_left = 16'hA5C3; audio_right = 16'h0F0F; mute = 1'b0;
    wait_cnt(0);
    audio_left = 16'h0; audio_right = 16'h0;
    read_frame(bits);
    // slot0 = 0, L = 1010_0101_1100_0011, R[15:1] = 000_0111_1000_0111
    n_cmp++; if (bits !== 32'h52E18787) begin n_bad++; $display("FAIL frame_a5c3_0f0f: got %h want 52e18787", bits); end
    wait_cnt(8);
    n_cmp++; if (audio_sdin !== 1'b1) begin n_bad++; $display("FAIL frame_r_lsb_slot0: got %b want 1", audio_sdin); end
  endtask

  task automatic test_mute;
    logic [31:0] bits;
    wait_cnt(400);
    audio_left = 16'hFFFF; audio_right = 16'hFFFF; mute = 1'b1;
    wait_cnt(0);
    mute = 1'b0; audio_left = 16'h0; audio_right = 16'h0;
    read_frame(bits);
    n_cmp++; if (bits !== 32'h0) begin n_bad++; $display("FAIL mute_frame: got %h want 00000000", bits); end
  endtask

  task automatic test_midframe;
    logic [31:0] bits;
    audio_left = 16'h1234; audio_right = 16'h0; mute = 1'b0;
    bits = '0;
    for (int s = 0; s < 32; s++) begin
      if (s == 6)  begin wait_cnt(100); audio_left = 16'h8000; end
      if (s == 12) begin wait_cnt(190); mute = 1'b1; end
      if (s == 18) begin wait_cnt(290); mute = 1'b0; end
      wait_cnt(s * 16 + 8);
      bits = {bits[30:0], audio_sdin};
    end
    n_cmp++; if (bits !== 32'h091A0000) begin n_bad++; $display("FAIL inflight_1234: got %h want 091a0000", bits); end
    read_frame(bits);
    n_cmp++; if (bits !== 32'h40000000) begin n_bad++; $display("FAIL next_8000: got %h want 40000000", bits); end
  endtask

  task automatic test_lsb_carry;
    audio_left = 16'h0; audio_right = 16'h0001;
    wait_cnt(8);
    n_cmp++; if (audio_sdin !== 1'b0) begin n_bad++; $display("FAIL carry_slot0_first: got %b want 0", audio_sdin); end
    audio_right = 16'h0000;
    wait_cnt(8);
    n_cmp++; if (audio_sdin !== 1'b1) begin n_bad++; $display("FAIL carry_slot0_second: got %b want 1", audio_sdin); end
    wait_cnt(8);
    n_cmp++; if (audio_sdin !== 1'b0) begin n_bad++; $display("FAIL carry_slot0_third: got %b want 0", audio_sdin); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] bits;
    int errs, first_req;
    logic [2:0] taps8;
    audio_left = 16'hFFFF; audio_right = 16'hFFFF;
    wait_cnt(0);
    wait_cnt(300);
    // cnt 300 = 1_0010_1100: slot 18 carries R[14] = 1, sck = 1, lrck = 1
    n_cmp++; if ({audio_sdin, audio_sck, audio_lrck} !== 3'b111) begin n_bad++; $display("FAIL pre_reset_300: got %b want 111", {audio_sdin, audio_sck, audio_lrck}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 5'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b want 00000", {sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0; first_req = -1; taps8 = 3'bxxx;
    for (int k = 1; k <= 511; k++) begin
      @(negedge clk);
      if (audio_sdin !== 1'b0) errs++;
      if (sample_req === 1'b1 && first_req < 0) first_req = k;
      if (k == 8) taps8 = {audio_lrck, audio_sck, audio_mclk};
    end
    n_cmp++; if (taps8 !== 3'b010) begin n_bad++; $display("FAIL restart_taps_cnt8: got %b want 010", taps8); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL post_reset_zero_frame: %0d nonzero cycles, want 0", errs); end
    n_cmp++; if (first_req != 511) begin n_bad++; $display("FAIL post_reset_first_req: at %0d want 511", first_req); end
    read_frame(bits);
    n_cmp++; if (bits !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL post_reset_ffff: got %h want 7fffffff", bits); end
  endtask

  initial begin
    test_reset;
    test_clocks;
    test_frame;
    test_mute;
    test_midframe;
    test_lsb_carry;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
